// File: rtl/gpio_responder.sv
// gpio_responder: memory-mapped GPIO register block on the data-side
// peripheral bus. Register select is address[4:2], so the eight registers
// alias across the whole window. Every accepted access produces exactly one
// single-cycle gpio_valid response.
//
// Optional build macro GPIO_EDGE_IRQ_EN: when defined, rising-edge capture
// (EDGE_STATUS / EDGE_EN) and the level interrupt gpio_irq are built. When
// undefined, offsets 5 and 6 read 0, writes to them are acknowledged and
// dropped, and gpio_irq is tied low.
module gpio_responder #(
  parameter int          GPIO_WIDTH   = 32,
  parameter int          ADDRESS_BITS = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] GPIO_ID      = 32'h6770_0001
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    gpio_read,
  input  logic                    gpio_write,
  input  logic [ADDRESS_BITS-1:0] gpio_address_in,
  input  logic [DATA_WIDTH-1:0]   gpio_data_in,
  output logic [DATA_WIDTH-1:0]   gpio_data_out,
  output logic [ADDRESS_BITS-1:0] gpio_address_out,
  output logic                    gpio_valid,
  output logic                    gpio_ready,
  input  logic [GPIO_WIDTH-1:0]   gpio_pins_in,
  output logic [GPIO_WIDTH-1:0]   gpio_pins_out,
  output logic [GPIO_WIDTH-1:0]   gpio_pins_oe,
  output logic                    gpio_irq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [2:0] SEL_DATA_IN  = 3'd0;
  localparam logic [2:0] SEL_DATA_OUT = 3'd1;
  localparam logic [2:0] SEL_DIR      = 3'd2;
  localparam logic [2:0] SEL_SET      = 3'd3;
  localparam logic [2:0] SEL_CLR      = 3'd4;
  localparam logic [2:0] SEL_EDGE_ST  = 3'd5;
  localparam logic [2:0] SEL_EDGE_EN  = 3'd6;
  localparam logic [2:0] SEL_ID       = 3'd7;

  logic [0:0]              r_state;
  logic                    r_ready;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data_out;
  logic [ADDRESS_BITS-1:0] r_addr_out;
  logic [GPIO_WIDTH-1:0]   r_dout;
  logic [GPIO_WIDTH-1:0]   r_dir;
  logic [GPIO_WIDTH-1:0]   r_sync1;
  logic [GPIO_WIDTH-1:0]   r_sync2;

  logic                    w_accept;
  logic                    w_wr;
  logic                    w_rd;
  logic [2:0]              w_sel;
  logic [GPIO_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH-1:0]   w_rdata;

  // r_ready is registered so it stays low through reset and rises on the
  // first clean edge; requests are only taken while it is high.
  assign w_accept = (r_state == ST_IDLE) && r_ready && (gpio_read || gpio_write);
  // read+write together is a write
  assign w_wr     = w_accept && gpio_write;
  assign w_rd     = w_accept && gpio_read && !gpio_write;
  assign w_sel    = gpio_address_in[4:2];
  assign w_wdata  = gpio_data_in[GPIO_WIDTH-1:0];

`ifdef GPIO_EDGE_IRQ_EN
  logic [GPIO_WIDTH-1:0] r_prev;
  logic [GPIO_WIDTH-1:0] r_stat;
  logic [GPIO_WIDTH-1:0] r_en;
  logic                  r_irq;
  logic [GPIO_WIDTH-1:0] w_rise;
  logic [GPIO_WIDTH-1:0] w_w1c;

  assign w_rise = r_sync2 & ~r_prev;
  assign w_w1c  = (w_wr && (w_sel == SEL_EDGE_ST)) ? w_wdata : '0;

  // Edge capture: clear written bits first, then OR in new rises so a
  // rise in the same cycle as a W1C keeps the bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev <= '0;
      r_stat <= '0;
      r_en   <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= r_sync2;
      r_stat <= (r_stat & ~w_w1c) | (w_rise & r_en);
      if (w_wr && (w_sel == SEL_EDGE_EN)) r_en <= w_wdata;
      r_irq  <= |(r_stat & r_en);
    end
  end

  assign gpio_irq = r_irq;
`else
  assign gpio_irq = 1'b0;
`endif

  // Read mux; write-only and absent registers return 0.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_DATA_IN:  w_rdata[GPIO_WIDTH-1:0] = r_sync2;
      SEL_DATA_OUT: w_rdata[GPIO_WIDTH-1:0] = r_dout;
      SEL_DIR:      w_rdata[GPIO_WIDTH-1:0] = r_dir;
`ifdef GPIO_EDGE_IRQ_EN
      SEL_EDGE_ST:  w_rdata[GPIO_WIDTH-1:0] = r_stat;
      SEL_EDGE_EN:  w_rdata[GPIO_WIDTH-1:0] = r_en;
`endif
      SEL_ID:       w_rdata = DATA_WIDTH'(GPIO_ID);
      default:      w_rdata = '0;
    endcase
  end

  // Two-state handshake FSM: accept in IDLE, one response cycle in RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_data_out <= '0;
      r_addr_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (w_accept) begin
            r_state    <= ST_RESP;
            r_ready    <= 1'b0;
            r_valid    <= 1'b1;
            r_addr_out <= gpio_address_in;
            r_data_out <= w_rd ? w_rdata : '0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Output and direction registers, including SET/CLR side-effects.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dout <= '0;
      r_dir  <= '0;
    end else if (w_wr) begin
      case (w_sel)
        SEL_DATA_OUT: r_dout <= w_wdata;
        SEL_DIR:      r_dir  <= w_wdata;
        SEL_SET:      r_dout <= r_dout | w_wdata;
        SEL_CLR:      r_dout <= r_dout & ~w_wdata;
        default:      r_dout <= r_dout;
      endcase
    end
  end

  // Two-flop pin synchronizer; r_sync2 is the value DATA_IN reports.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_pins_in;
      r_sync2 <= r_sync1;
    end
  end

  assign gpio_ready       = r_ready;
  assign gpio_valid       = r_valid;
  assign gpio_data_out    = r_data_out;
  assign gpio_address_out = r_addr_out;
  assign gpio_pins_out    = r_dout;
  assign gpio_pins_oe     = r_dir;

endmodule
